// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle short/long/double/repeat events.
// All gesture timing is counted in milliseconds derived from CLK_HZ.
module button_event_decoder #(
    parameter int   CLK_HZ          = 100_000_000,
    parameter logic ACTIVE_LEVEL    = 1'b0,
    parameter int   LONG_PRESS_MS   = 1000,
    parameter int   DOUBLE_CLICK_MS = 300,
    parameter int   REPEAT_MS       = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn_level,
    output logic       btn_held,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       repeat_tick,
    output logic       event_valid,
    output logic [1:0] event_code
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, PRESS1, HOLD, WAIT2, PRESS2} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   pre_cnt;
    logic            ms_tick;
    logic [15:0]     ms_cnt;
    logic [15:0]     rep_cnt;
    logic            pressed;
    // ev_d bit order: {repeat, double, long, short}
    logic [3:0]      ev_d;
    logic [1:0]      code_d;

    assign pressed = (btn_level == ACTIVE_LEVEL);
    assign ms_tick = (pre_cnt == PW'(DIV - 1));

    // Free-running prescaler; deliberately not tied to state changes.
    always_ff @(posedge clk) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= ms_tick ? '0 : pre_cnt + PW'(1);
    end

    always_comb begin
        state_d = state;
        ev_d    = 4'b0000;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (pressed) state_d = PRESS1;
                PRESS1: begin
                    if (!pressed) begin
                        if (DOUBLE_CLICK_MS != 0) begin
                            state_d = WAIT2;
                        end else begin
                            state_d = IDLE;
                            ev_d[0] = 1'b1;
                        end
                    end else if (ms_tick && ms_cnt == 16'(LONG_PRESS_MS - 1)) begin
                        state_d = HOLD;
                        ev_d[1] = 1'b1;
                    end
                end
                HOLD: begin
                    if (!pressed)
                        state_d = IDLE;
                    else if (REPEAT_MS != 0 && ms_tick && rep_cnt == 16'(REPEAT_MS - 1))
                        ev_d[3] = 1'b1;
                end
                WAIT2: begin
                    if (pressed) begin
                        state_d = PRESS2;
                    end else if (ms_tick && ms_cnt == 16'(DOUBLE_CLICK_MS - 1)) begin
                        state_d = IDLE;
                        ev_d[0] = 1'b1;
                    end
                end
                PRESS2: begin
                    if (!pressed) begin
                        state_d = IDLE;
                        ev_d[2] = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        code_d = 2'd0;
        if (ev_d[3])      code_d = 2'd3;
        else if (ev_d[2]) code_d = 2'd2;
        else if (ev_d[1]) code_d = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Per-state ms counter, restarted on every transition; saturates.
    always_ff @(posedge clk) begin
        if (rst || !enable || state_d != state) ms_cnt <= '0;
        else if (ms_tick && ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;
    end

    // Only counts ticks while staying in HOLD, so the entry tick is excluded.
    always_ff @(posedge clk) begin
        if (rst || state != HOLD || state_d != HOLD) rep_cnt <= '0;
        else if (ev_d[3])                            rep_cnt <= '0;
        else if (ms_tick)                            rep_cnt <= rep_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_held     <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            repeat_tick  <= 1'b0;
            event_valid  <= 1'b0;
            event_code   <= 2'd0;
        end else begin
            btn_held     <= (state_d == PRESS1) || (state_d == HOLD) || (state_d == PRESS2);
            short_press  <= ev_d[0];
            long_press   <= ev_d[1];
            double_click <= ev_d[2];
            repeat_tick  <= ev_d[3];
            event_valid  <= |ev_d;
            if (|ev_d) event_code <= code_d;
        end
    end

endmodule
